// File: rtl/if_id_queue.sv
// Instruction queue between IF and ID: DEPTH-entry circular buffer with valid/ready on both sides.
// Optional zero-latency empty-queue bypass is enabled by defining IFID_BYPASS_EN.

`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef INST_BUS_WIDTH
`define INST_BUS_WIDTH 32
`endif

module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = `ADDR_BUS_WIDTH,
  parameter int INST_W = `INST_BUS_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  input  logic                       if_pre_taken,
  input  logic [ADDR_W-1:0]          if_pre_addr,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic                       id_pre_taken,
  output logic [ADDR_W-1:0]          id_pre_addr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              pre_taken;
    logic [ADDR_W-1:0] pre_addr;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   occ;

  entry_t in_entry;
  entry_t head;
  logic   empty;
  logic   full;
  logic   push;
  logic   pop;

  assign in_entry = '{pc: if_pc, inst: if_inst, pre_taken: if_pre_taken, pre_addr: if_pre_addr};
  assign empty    = (occ == '0);
  assign full     = (occ == FULL_CNT);
  assign if_ready = !full;
  assign count    = occ;

  // Array-side pop only; a bypassed entry never touches the pointers.
  assign pop = !empty && id_ready && !flush;

`ifdef IFID_BYPASS_EN
  logic bypass;
  assign bypass = empty && !flush;
  assign push   = if_valid && if_ready && !flush && !(bypass && id_ready);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    id_valid = 1'b0;
    head     = '0;
    if (bypass) begin
      id_valid = if_valid;
      head     = in_entry;
    end else if (!empty) begin
      id_valid = 1'b1;
      head     = mem[rd_ptr];
    end
  end
`else
  assign push = if_valid && if_ready && !flush;

  always_comb begin
    id_valid = 1'b0;
    head     = '0;
    if (!empty) begin
      id_valid = 1'b1;
      head     = mem[rd_ptr];
    end
  end
`endif

  assign id_pc        = head.pc;
  assign id_inst      = head.inst;
  assign id_pre_taken = head.pre_taken;
  assign id_pre_addr  = head.pre_addr;

  // NOTE: payload storage is deliberately not reset; stale entries are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4, 32-bit buses).
// Expected values are hand-computed; the wrap-around phase uses a small queue model.

module tb_if_id_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_pre_taken;
  logic [ADDR_W-1:0] if_pre_addr;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_pre_taken;
  logic [ADDR_W-1:0] id_pre_addr;
  logic [2:0]        count;

  int n_assert = 0;
  int n_fail   = 0;

  if_id_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_pre_taken(if_pre_taken), .if_pre_addr(if_pre_addr),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .id_pre_taken(id_pre_taken), .id_pre_addr(id_pre_addr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a fetch entry; inst/target are derived from the PC so payload integrity is checkable.
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    if_valid     = v;
    if_pc        = pc;
    if_inst      = pc ^ 32'hA5A5_0000;
    if_pre_taken = pc[2];
    if_pre_addr  = pc + 32'h40;
    id_ready     = rdy;
  endtask

  logic [31:0] model_q[$];
  logic [31:0] exp_pc;
  int          pushed;
  int          popped;
  logic        do_push;
  logic        do_pop;

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    check("reset_count", 64'(count), 64'd0);
    check("reset_id_valid", 64'(id_valid), 64'd0);
    check("reset_if_ready", 64'(if_ready), 64'd1);
    check("reset_id_pc", 64'(id_pc), 64'd0);
    rst = 1'b0;

    // Reset mid-traffic
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h10 + 32'(4*i), 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    check("pre_rst_count", 64'(count), 64'd3);
    check("pre_rst_head", 64'(id_pc), 64'h10);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_id_valid", 64'(id_valid), 64'd0);
    check("async_rst_id_pc", 64'(id_pc), 64'd0);
    check("async_rst_if_ready", 64'(if_ready), 64'd1);
    tick();
    rst = 1'b0;

    // Fill to DEPTH, then one ignored push
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4*i), 1'b0);
      tick();
    end
    check("full_count", 64'(count), 64'd4);
    check("full_if_ready", 64'(if_ready), 64'd0);
    drive(1'b1, 32'h110, 1'b0);
    tick();
    check("overflow_count", 64'(count), 64'd4);
    check("overflow_head", 64'(id_pc), 64'h100);

    // Drain in FIFO order, payload fields intact
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'h100 + 32'(4*i);
      check("drain_valid", 64'(id_valid), 64'd1);
      check("drain_pc", 64'(id_pc), 64'(exp_pc));
      check("drain_inst", 64'(id_inst), 64'(exp_pc ^ 32'hA5A5_0000));
      check("drain_taken", 64'(id_pre_taken), 64'(exp_pc[2]));
      check("drain_target", 64'(id_pre_addr), 64'(exp_pc + 32'h40));
      tick();
    end
    check("drained_valid", 64'(id_valid), 64'd0);
    check("drained_count", 64'(count), 64'd0);
    check("drained_pc_zero", 64'(id_pc), 64'd0);

    // Simultaneous push+pop at count 2
    drive(1'b1, 32'h200, 1'b0); tick();
    drive(1'b1, 32'h204, 1'b0); tick();
    check("pp_pre_count", 64'(count), 64'd2);
    drive(1'b1, 32'h208, 1'b1); tick();
    check("pp_count", 64'(count), 64'd2);
    check("pp_head", 64'(id_pc), 64'h204);
    drive(1'b0, 32'h0, 1'b1); tick();
    check("pp_next_head", 64'(id_pc), 64'h208);
    tick();
    check("pp_empty", 64'(id_valid), 64'd0);

    // Flush at count 3 with push and pop both requested
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4*i), 1'b0);
      tick();
    end
    check("fl_pre_count", 64'(count), 64'd3);
    drive(1'b1, 32'h30C, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_id_valid", 64'(id_valid), 64'd0);
    check("flush_if_ready", 64'(if_ready), 64'd1);
    tick();
    check("flush_no_store", 64'(count), 64'd0);
    drive(1'b1, 32'h400, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0);
    check("post_flush_head", 64'(id_pc), 64'h400);
    drive(1'b0, 32'h0, 1'b1); tick();
    check("post_flush_empty", 64'(count), 64'd0);

    // Wrap-around with random consumer stalls against a queue model
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 200 && popped < 10; cyc++) begin
      drive(pushed < 10, 32'h500 + 32'(4*pushed), 1'($urandom_range(0, 1)));
      do_push = if_valid && (model_q.size() < DEPTH);
      do_pop  = id_ready && (model_q.size() > 0);
      #1;
      if (do_pop) begin
        check("wrap_valid", 64'(id_valid), 64'd1);
        check("wrap_pc", 64'(id_pc), 64'(model_q[0]));
      end
      check("wrap_if_ready", 64'(if_ready), 64'(model_q.size() < DEPTH));
      tick();
      if (do_pop) begin
        void'(model_q.pop_front());
        popped++;
      end
      if (do_push) begin
        model_q.push_back(if_pc);
        pushed++;
      end
      check("wrap_count", 64'(count), 64'(model_q.size()));
    end
    check("wrap_all_popped", 64'(popped), 64'd10);
    drive(1'b0, 32'h0, 1'b0);

    // Empty-queue latency
    if_valid = 1'b1;
    if_inst  = 32'h2402_0001;
    if_pc    = 32'h600;
    id_ready = 1'b0;
    #1;
`ifdef IFID_BYPASS_EN
    check("byp_valid_same_cycle", 64'(id_valid), 64'd1);
    check("byp_inst_same_cycle", 64'(id_inst), 64'h2402_0001);
    id_ready = 1'b1;
    tick();
    if_valid = 1'b0;
    id_ready = 1'b0;
    check("byp_consumed_count", 64'(count), 64'd0);
`else
    check("lat_not_same_cycle", 64'(id_valid), 64'd0);
    tick();
    if_valid = 1'b0;
    check("lat_valid_next", 64'(id_valid), 64'd1);
    check("lat_inst_next", 64'(id_inst), 64'h2402_0001);
    check("lat_count", 64'(count), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
